// File: rtl/operand_sequencer.sv
// operand_sequencer: buffers operand pairs in a small FIFO and issues them one
// at a time to a downstream fixed-latency serial adder, captures the sum after
// LAT cycles and holds it until the consumer accepts it.
// Optional feature macro OPSEQ_SUMCHECK_EN: when defined, the captured sum is
// compared against a local 8-bit add and res_err flags a mismatch; when
// undefined there is no comparator and res_err is tied low.
module operand_sequencer #(
    parameter int DEPTH = 4,
    parameter int LAT   = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       add_en,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    input  logic [7:0] add_sum,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_sum,
    output logic       res_err,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
    localparam logic [3:0] LAT_LAST = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        r_state, w_next;
    logic [7:0]    r_mem_a [DEPTH];
    logic [7:0]    r_mem_b [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_occ;
    logic [3:0]    r_wcnt;
    logic [7:0]    r_op_a, r_op_b, r_sum;
    logic          w_push, w_pop, w_capture;

    // Acceptance depends on occupancy only, so a full FIFO never takes a push.
    assign in_ready = (r_occ < FULL_OCC);
    assign w_push   = in_valid && in_ready;
    assign res_sum  = r_sum;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and outputs; the FIFO head drives add_a/add_b during ISSUE so
    // the adder sees the operands in the same cycle as the add_en pulse.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_capture = 1'b0;
        add_en    = 1'b0;
        add_a     = r_op_a;
        add_b     = r_op_b;
        res_valid = 1'b0;
        busy      = (r_state != IDLE);
        case (r_state)
            IDLE: if (r_occ != '0) w_next = ISSUE;
            ISSUE: begin
                w_pop  = 1'b1;
                add_en = 1'b1;
                add_a  = r_mem_a[r_rptr];
                add_b  = r_mem_b[r_rptr];
                w_next = WAIT;
            end
            WAIT: if (r_wcnt == LAT_LAST) begin
                w_capture = 1'b1;
                w_next    = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // FIFO storage; contents need no reset because pointers/occupancy gate use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wptr] <= in_a;
            r_mem_b[r_wptr] <= in_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Operand latch at issue, wait counter, and sum capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_wcnt <= '0;
            r_sum  <= '0;
        end else begin
            if (w_pop) begin
                r_op_a <= r_mem_a[r_rptr];
                r_op_b <= r_mem_b[r_rptr];
                r_wcnt <= '0;
            end else if (r_state == WAIT) begin
                r_wcnt <= r_wcnt + 4'd1;
            end
            if (w_capture) r_sum <= add_sum;
        end
    end

`ifdef OPSEQ_SUMCHECK_EN
    logic r_err;
    assign res_err = r_err;

    // Compare the adder result against the operands it was given.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_err <= 1'b0;
        else if (w_capture) r_err <= (add_sum != 8'(r_op_a + r_op_b));
    end
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
// Testbench for operand_sequencer: scoreboard of expected results filled as
// operands are accepted, drained as the sequencer issues and returns results.
module tb_operand_sequencer;
    localparam int LAT   = 9;
    localparam int DEPTH = 4;

    typedef struct { logic [7:0] a, b; } pair_t;
    typedef struct { logic [7:0] a, b, sum; logic err; } exp_t;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, add_en, res_valid, res_ready, res_err, busy;
    logic [7:0] in_a, in_b, add_a, add_b, add_sum, res_sum;
    logic [7:0] stub_xor;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    pair_t stim_q[$];
    exp_t  exp_q[$];

    int         acc_cyc [8];
    logic       rdy_after [8];
    bit         drv_to;
    bit         o_to [8], o_pulse [8], o_glitch [8], o_stable [8];
    int         o_ti [8], o_tr [8], o_tack [8];
    logic [7:0] o_a [8], o_b [8], o_sum [8];
    logic       o_err [8];

    operand_sequencer #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .add_en(add_en), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial adder stand-in; stub_xor corrupts the result on demand.
    assign add_sum = 8'(add_a + add_b) ^ stub_xor;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        e.sum = 8'(a + b) ^ stub_xor;
`ifdef OPSEQ_SUMCHECK_EN
        e.err = (stub_xor != 8'h00);
`else
        e.err = 1'b0;
`endif
        return e;
    endfunction

    // Offer every queued pair in order, holding each until accepted.
    task automatic push_all();
        int n;
        n = stim_q.size();
        drv_to = 0;
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            in_valid = 1'b1;
            in_a = stim_q[i].a;
            in_b = stim_q[i].b;
            while (in_ready !== 1'b1 && w < 300) begin @(negedge clk); w++; end
            if (in_ready !== 1'b1) begin drv_to = 1; break; end
            exp_q.push_back(model(stim_q[i].a, stim_q[i].b));
            acc_cyc[i] = cyc;
            @(negedge clk);
            rdy_after[i] = in_ready;
        end
        in_valid = 1'b0;
        stim_q.delete();
    endtask

    // Record one issue/result transaction; hold res_ready low for 'hold' cycles.
    task automatic observe(input int k, input int hold);
        int w;
        o_to[k] = 0; o_glitch[k] = 0; o_stable[k] = 1; o_pulse[k] = 0;
        w = 0;
        while (add_en !== 1'b1 && w < 300) begin @(negedge clk); w++; end
        if (add_en !== 1'b1) begin o_to[k] = 1; return; end
        o_ti[k] = cyc; o_a[k] = add_a; o_b[k] = add_b;
        @(negedge clk);
        o_pulse[k] = (add_en === 1'b0);
        w = 0;
        while (res_valid !== 1'b1 && w < 40) begin
            if (add_en !== 1'b0 || add_a !== o_a[k] || add_b !== o_b[k]) o_glitch[k] = 1;
            @(negedge clk); w++;
        end
        if (res_valid !== 1'b1) begin o_to[k] = 1; return; end
        o_tr[k] = cyc; o_sum[k] = res_sum; o_err[k] = res_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_sum !== o_sum[k] || res_err !== o_err[k] ||
                add_en !== 1'b0 || add_a !== o_a[k] || add_b !== o_b[k]) o_stable[k] = 0;
        end
        res_ready = 1'b1;
        o_tack[k] = cyc;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({add_en, res_valid, res_err, busy, in_ready} !== 5'b00001) begin
            n_errors++;
            $display("FAIL reset_ctrl: {add_en,res_valid,res_err,busy,in_ready}=%b required 00001",
                     {add_en, res_valid, res_err, busy, in_ready});
        end
        n_checks++;
        if ({add_a, add_b, res_sum} !== 24'h0) begin
            n_errors++;
            $display("FAIL reset_data: add_a=%h add_b=%h res_sum=%h required 00 00 00", add_a, add_b, res_sum);
        end
    endtask

    task automatic test_single();
        exp_t e;
        stub_xor = 8'h00;
        stim_q.push_back('{8'h12, 8'h34});
        fork push_all(); observe(0, 0); join
        e = exp_q.pop_front();
        n_checks++;
        if (o_to[0]) begin n_errors++; $display("FAIL single_timeout: no result seen, required one"); end
        n_checks++;
        if ({o_a[0], o_b[0]} !== {e.a, e.b}) begin
            n_errors++; $display("FAIL single_ops: add_a/b=%h/%h required %h/%h", o_a[0], o_b[0], e.a, e.b);
        end
        n_checks++;
        if (!o_pulse[0] || o_glitch[0]) begin
            n_errors++; $display("FAIL single_pulse: pulse_ok=%0d glitch=%0d required 1/0", o_pulse[0], o_glitch[0]);
        end
        n_checks++;
        if (o_tr[0] - o_ti[0] !== LAT + 1) begin
            n_errors++; $display("FAIL single_latency: %0d required %0d", o_tr[0] - o_ti[0], LAT + 1);
        end
        n_checks++;
        if (o_sum[0] !== 8'h46 || o_sum[0] !== e.sum) begin
            n_errors++; $display("FAIL single_sum: %h required 46", o_sum[0]);
        end
        n_checks++;
        if (o_err[0] !== 1'b0) begin n_errors++; $display("FAIL single_err: %b required 0", o_err[0]); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            stub_xor = (k == 0) ? 8'h00 : 8'h03;
            stim_q.push_back('{8'hFF, 8'h02});
            fork push_all(); observe(k, 0); join
            e = exp_q.pop_front();
            n_checks++;
            if (o_to[k]) begin n_errors++; $display("FAIL wrap_timeout op%0d: no result, required one", k); end
            n_checks++;
            if (o_sum[k] !== e.sum) begin
                n_errors++; $display("FAIL wrap_sum op%0d: %h required %h", k, o_sum[k], e.sum);
            end
            n_checks++;
            if (o_err[k] !== e.err) begin
                n_errors++; $display("FAIL wrap_err op%0d: %b required %b", k, o_err[k], e.err);
            end
        end
        stub_xor = 8'h00;
    endtask

    task automatic test_full();
        stub_xor = 8'h00;
        for (int i = 0; i < 6; i++) stim_q.push_back('{8'(i * 16 + 1), 8'(i + 2)});
        fork
            push_all();
            begin
                observe(0, 10);
                for (int k = 1; k < 6; k++) observe(k, 0);
            end
        join
        n_checks++;
        if (drv_to) begin n_errors++; $display("FAIL full_push: driver stalled, required all 6 accepted"); end
        n_checks++;
        if (rdy_after[4] !== 1'b0) begin
            n_errors++; $display("FAIL full_ready: in_ready=%b after 5th push required 0", rdy_after[4]);
        end
        n_checks++;
        if (acc_cyc[5] !== o_ti[1] + 1) begin
            n_errors++; $display("FAIL full_stall: 6th accepted cycle %0d required %0d", acc_cyc[5], o_ti[1] + 1);
        end
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (o_to[k] || {o_a[k], o_b[k], o_sum[k]} !== {e.a, e.b, e.sum}) begin
                n_errors++;
                $display("FAIL full_op%0d: to=%0d a/b/sum=%h/%h/%h required %h/%h/%h",
                         k, o_to[k], o_a[k], o_b[k], o_sum[k], e.a, e.b, e.sum);
            end
        end
    endtask

    task automatic test_backpressure();
        stub_xor = 8'h00;
        stim_q.push_back('{8'h20, 8'h05});
        stim_q.push_back('{8'h40, 8'h07});
        fork push_all(); begin observe(0, 20); observe(1, 0); end join
        n_checks++;
        if (o_to[0] || !o_stable[0]) begin
            n_errors++; $display("FAIL bp_stable: to=%0d stable=%0d required 0/1", o_to[0], o_stable[0]);
        end
        n_checks++;
        if (o_to[1] || o_ti[1] !== o_tack[0] + 2) begin
            n_errors++; $display("FAIL bp_reissue: add_en at %0d required %0d", o_ti[1], o_tack[0] + 2);
        end
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (o_sum[k] !== e.sum) begin
                n_errors++; $display("FAIL bp_sum op%0d: %h required %h", k, o_sum[k], e.sum);
            end
        end
    endtask

    task automatic test_order();
        stub_xor = 8'h00;
        stim_q.push_back('{8'h01, 8'h02});
        stim_q.push_back('{8'h03, 8'h04});
        stim_q.push_back('{8'h05, 8'h06});
        fork push_all(); for (int k = 0; k < 3; k++) observe(k, 0); join
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (o_to[k] || {o_a[k], o_b[k]} !== {e.a, e.b}) begin
                n_errors++; $display("FAIL order_ops op%0d: %h/%h required %h/%h", k, o_a[k], o_b[k], e.a, e.b);
            end
            n_checks++;
            if (o_sum[k] !== e.sum) begin
                n_errors++; $display("FAIL order_sum op%0d: %h required %h", k, o_sum[k], e.sum);
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_ti[k + 1] - o_ti[k] !== LAT + 3) begin
                n_errors++; $display("FAIL order_rate op%0d: spacing %0d required %0d", k, o_ti[k + 1] - o_ti[k], LAT + 3);
            end
        end
    endtask

    task automatic test_reset_wait();
        bit seen, bad;
        stub_xor = 8'h00;
        seen = 0; bad = 0;
        for (int i = 0; i < 3; i++) stim_q.push_back('{8'(i + 9), 8'(i + 1)});
        fork
            push_all();
            begin
                for (int w = 0; w < 100 && !seen; w++) begin
                    if (add_en === 1'b1) seen = 1; else @(negedge clk);
                end
                repeat (3) @(negedge clk);
                rst = 1'b1;
            end
        join
        exp_q.delete();
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL rstw_issue: no add_en before reset, required one"); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL rstw_idle: busy=%b in_ready=%b required 0/1", busy, in_ready);
        end
        for (int i = 0; i < 30; i++) begin
            if (res_valid !== 1'b0 || add_en !== 1'b0) bad = 1;
            @(negedge clk);
        end
        n_checks++;
        if (bad) begin n_errors++; $display("FAIL rstw_quiet: res_valid/add_en seen after reset, required none"); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0; stub_xor = 8'h00;
        test_reset();
        test_single();
        test_wrap();
        test_full();
        test_backpressure();
        test_order();
        test_reset_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-002 SHALL provide parameter LAT, default 9, cycles from add_en pulse to sum capture (range 1..15).
REQ-003 SHALL provide clk  input  1  clock, rising-edge.
REQ-004 SHALL provide rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide in_valid  input  1  operand pair offered.
REQ-006 SHALL provide in_ready  output  1  FIFO can accept.
REQ-007 SHALL provide in_a, in_b  input  8 each  operands.
REQ-008 SHALL provide add_en  output  1  one-cycle start pulse to downstream serial adder.
REQ-009 SHALL provide add_a, add_b  output  8 each  operands to serial adder.
REQ-010 SHALL provide add_sum  input  8  serial adder result.
REQ-011 SHALL provide res_valid  output  1  result available.
REQ-012 SHALL provide res_ready  input  1  result consumer accepts.
REQ-013 SHALL provide res_sum  output  8  captured sum.
REQ-014 SHALL provide res_err  output  1  check mismatch flag, qualified by res_valid.
REQ-015 SHALL provide busy  output  1  high in any state other than IDLE.

Function
REQ-016 FIFO: push on in_valid && in_ready; in_ready = (occupancy < DEPTH); read/write pointers wrap modulo DEPTH.
REQ-017 Full FIFO: in_ready low; push/pop in same cycle when full not possible since in_ready is registered-free combinational on occupancy only; no overwrite ever.
REQ-018 Simultaneous push and pop (non-full): occupancy unchanged, both operations performed.
REQ-019 FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-020 IDLE -> ISSUE when FIFO non-empty; else remain.
REQ-021 ISSUE: pop FIFO head into op_a/op_b registers, add_en = 1 for exactly this cycle, next state WAIT, wait counter cleared.
REQ-022 add_a/add_b SHALL equal the popped operands from the ISSUE cycle through HOLD (held stable until next ISSUE).
REQ-023 WAIT: counter increments each cycle; on the LAT-th WAIT cycle, add_sum captured into res_sum, next state HOLD.
REQ-024 add_en at cycle T -> res_valid first high at cycle T+LAT+1.
REQ-025 HOLD: res_valid = 1, res_sum and res_err stable; on res_ready -> IDLE; else remain.
REQ-026 Back-to-back throughput: one result per LAT+3 cycles minimum (HOLD->IDLE->ISSUE).
REQ-027 in_valid/push accepted in every state including WAIT and HOLD.
REQ-028 add_en SHALL never assert while a previous operation is in WAIT or HOLD.

Reset
REQ-029 rst asserted: state IDLE, FIFO empty, pointers/counter 0, add_en 0, add_a/add_b 0, res_valid 0, res_sum 0, res_err 0, busy 0, in_ready 1 after release.
REQ-030 Reset mid-operation: in-flight and queued operands discarded; no result delivered.

Configuration
REQ-031 Macro OPSEQ_SUMCHECK_EN defined: at capture, res_err = (add_sum != (op_a + op_b) mod 256), held with res_sum.
REQ-032 OPSEQ_SUMCHECK_EN undefined: no comparator; res_err tied 0; all other behaviour identical.

Verification
REQ-033 Single op: push a=0x12,b=0x34, stub add_sum=0x46 at capture -> add_en one cycle, res_valid at T+10 (LAT=9), res_sum=0x46, res_err=0.
REQ-034 Wrap: push 0xFF,0x02, stub returns 0x01 -> res_sum=0x01, res_err=0; stub 0x02 with OPSEQ_SUMCHECK_EN -> res_err=1, without -> 0.
REQ-035 Full: hold res_ready=0, push 6 pairs -> first popped, 4 buffered, in_ready low after 5th accepted, 6th stalled until next ISSUE.
REQ-036 Backpressure: res_ready=0 for 20 cycles -> res_valid/res_sum stable, no add_en; res_ready=1 -> next add_en 2 cycles later.
REQ-037 Order: push (1,2),(3,4),(5,6) -> add_a/add_b issued in same order, results 0x03,0x07,0x0B in order.
REQ-038 Reset in WAIT: assert rst 3 cycles after add_en with 2 queued -> res_valid never asserts, FIFO empty, busy 0, in_ready 1.
